// File: rtl/vedic_pipe_mult.sv
// vedic_pipe_mult: three-stage pipelined Urdhva-Tiryagbhyam (vertical and
// crosswise) multiplier. Each WxW product is built from four half-width
// partial products. Both unsigned and two's-complement operands are supported,
// selected per beat. The block has a valid/ready stream interface with a
// single global stall.
module vedic_pipe_mult #(
    parameter int W = 8  // operand width, even, 4..32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           tc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);

    localparam int H = W / 2;

    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    // Pipeline control.
    logic en;
    logic accept;
    logic v1, v2, v3;

    // Stage 1 registers: the four vertical/crosswise partial products.
    logic [W-1:0] ll1, lh1, hl1, hh1;
    logic         neg1;

    // Stage 2 registers: outer products plus the merged crosswise term.
    logic [W-1:0] ll2, hh2;
    logic [W:0]   cross2;
    logic         neg2;

    // Combinational terms feeding the stage registers.
    logic [W-1:0]   ma, mb;
    logic           neg_c;
    logic [W-1:0]   ll_c, lh_c, hl_c, hh_c;
    logic [W:0]     cross_c;
    logic [2*W-1:0] s_c;
    logic [2*W-1:0] p_c;

    // The whole pipeline moves together. It stalls only when a finished result
    // is waiting and the consumer refuses it.
    always_comb begin
        en       = !v3 || out_ready;
        in_ready = en && !rst;
        accept   = in_valid && in_ready;
    end

    assign out_valid = v3;

    // Stage 1 logic: convert operands to sign/magnitude, then form half-width products.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        ma    = a;
        mb    = b;
        neg_c = 1'b0;
        if (tc) begin
            // Negating -2^(W-1) in W bits gives 2^(W-1). As an unsigned
            // magnitude that value is correct, so no extra bit is needed.
            if (a[W-1]) ma = ~a + ONE_W;
            if (b[W-1]) mb = ~b + ONE_W;
            neg_c = a[W-1] ^ b[W-1];
        end
        ll_c = {{H{1'b0}}, ma[H-1:0]} * {{H{1'b0}}, mb[H-1:0]};
        lh_c = {{H{1'b0}}, ma[H-1:0]} * {{H{1'b0}}, mb[W-1:H]};
        hl_c = {{H{1'b0}}, ma[W-1:H]} * {{H{1'b0}}, mb[H-1:0]};
        hh_c = {{H{1'b0}}, ma[W-1:H]} * {{H{1'b0}}, mb[W-1:H]};
    end

    // Stage 2 logic: the crosswise sum keeps its carry (W+1 bits).
    always_comb begin
        cross_c = {1'b0, lh1} + {1'b0, hl1};
    end

    // Stage 3 logic: place the crosswise term at bit H, then restore the sign.
    // A zero magnitude with neg=1 negates to zero, so -0 never appears.
    always_comb begin
        s_c = {hh2, ll2} + {{(W-H-1){1'b0}}, cross2, {H{1'b0}}};
        p_c = neg2 ? (~s_c + ONE_2W) : s_c;
    end

    // Valid bits: bubbles move through the pipeline like data. Reset wins over a
    // simultaneous accept.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // stage samples its predecessor's pre-edge value.
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (en) begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Data registers: a stage loads only when a real beat enters it, so p
    // changes only when a new result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data path is cleared on reset as well, not just the
            // valid bits, because p is defined to read 0 out of reset.
            ll1    <= '0;
            lh1    <= '0;
            hl1    <= '0;
            hh1    <= '0;
            neg1   <= 1'b0;
            ll2    <= '0;
            hh2    <= '0;
            cross2 <= '0;
            neg2   <= 1'b0;
            p      <= '0;
        end else begin
            if (accept) begin
                ll1  <= ll_c;
                lh1  <= lh_c;
                hl1  <= hl_c;
                hh1  <= hh_c;
                neg1 <= neg_c;
            end
            if (en && v1) begin
                ll2    <= ll1;
                hh2    <= hh1;
                cross2 <= cross_c;
                neg2   <= neg1;
            end
            if (en && v2) begin
                p <= p_c;
            end
        end
    end

endmodule
